// File: rtl/zs_group_sched.sv
// Zero-skip group scheduler: packs the nonzero lanes of each activation group into
// GROUP_NZ_BITS-wide beats, splitting dense groups. Optional macro ZS_SCHED_SKIP_EMPTY_EN.
module zs_group_sched #(
  parameter int unsigned GROUP_SIZE    = 32,
  parameter int unsigned GROUP_NZ_BITS = 16,
  parameter int unsigned DATA_W        = 8,
  localparam int unsigned CNT_W    = $clog2(GROUP_NZ_BITS + 1),
  localparam int unsigned PASS_RAW = $clog2((GROUP_SIZE + GROUP_NZ_BITS - 1) / GROUP_NZ_BITS),
  localparam int unsigned PASS_W   = (PASS_RAW > 0) ? PASS_RAW : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [GROUP_SIZE-1:0]                  in_znz,
  input  logic [GROUP_SIZE-1:0][DATA_W-1:0]      in_act,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [GROUP_NZ_BITS-1:0][DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]                       out_cnt,
  output logic [PASS_W-1:0]                      out_pass,
  output logic                                   out_last
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                                 state_q, state_d;
  logic [GROUP_SIZE-1:0]                  rem_q, rem_d;
  logic [GROUP_SIZE-1:0][DATA_W-1:0]      act_q, act_d;
  logic [PASS_W-1:0]                      pass_q, pass_d;

  logic [GROUP_SIZE-1:0]                  sel_c;
  logic [CNT_W-1:0]                       cnt_c;
  logic [GROUP_NZ_BITS-1:0][DATA_W-1:0]   pack_c;
  logic                                   last_c;

  // Pick the lowest remaining nonzero lanes and compact them in ascending order.
  always_comb begin : sel_pack
    sel_c  = '0;
    cnt_c  = '0;
    pack_c = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (rem_q[i] && (cnt_c < CNT_W'(GROUP_NZ_BITS))) begin
        for (int k = 0; k < GROUP_NZ_BITS; k++) begin
          if (cnt_c == CNT_W'(k)) pack_c[k] = act_q[i];
        end
        sel_c[i] = 1'b1;
        cnt_c    = cnt_c + CNT_W'(1);
      end
    end
  end

  assign last_c   = ((rem_q & ~sel_c) == '0);
  assign out_data = (state_q == EMIT) ? pack_c : '0;
  assign out_cnt  = (state_q == EMIT) ? cnt_c : '0;
  assign out_pass = (state_q == EMIT) ? pass_q : '0;
  assign out_last = (state_q == EMIT) && last_c;

  // Next state; a new group may be taken on the handshake of the final beat.
  always_comb begin : fsm_next
    state_d   = state_q;
    rem_d     = rem_q;
    act_d     = act_q;
    pass_d    = pass_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rem_d  = rem_q & ~sel_c;
          pass_d = pass_q + PASS_W'(1);
          if (last_c) begin
            in_ready = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && in_ready) begin
      rem_d   = in_znz;
      act_d   = in_act;
      pass_d  = '0;
      state_d = EMIT;
`ifdef ZS_SCHED_SKIP_EMPTY_EN
      if (in_znz == '0) state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      act_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      act_q   <= act_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_zs_group_sched.sv
// Self-checking bench for zs_group_sched: queue-based beat model plus directed literal checks.
module tb_zs_group_sched;
  localparam int GS = 32;
  localparam int NZ = 16;
  localparam int DW = 8;
`ifdef ZS_SCHED_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid, in_ready, out_valid, out_ready, out_last;
  logic [GS-1:0]           in_znz;
  logic [GS-1:0][DW-1:0]   in_act;
  logic [NZ-1:0][DW-1:0]   out_data;
  logic [4:0]              out_cnt;
  logic [0:0]              out_pass;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [NZ*DW-1:0] data;
    int               cnt;
    int               pass;
    bit               last;
  } beat_t;
  beat_t exp_q[$];

  zs_group_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_znz(in_znz), .in_act(in_act), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_pass(out_pass), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected beats of one group: nonzero lanes in order, chunked NZ at a time.
  task automatic push_group(input logic [GS-1:0] znz, input logic [GS-1:0][DW-1:0] act);
    int    lanes[$];
    int    nb;
    beat_t b;
    for (int i = 0; i < GS; i++) if (znz[i]) lanes.push_back(i);
    nb = (lanes.size() + NZ - 1) / NZ;
    if (nb == 0) nb = SKIP ? 0 : 1;
    for (int j = 0; j < nb; j++) begin
      b.data = '0;
      b.cnt  = 0;
      for (int k = 0; k < NZ; k++) begin
        if (j * NZ + k < lanes.size()) begin
          b.data[k*DW +: DW] = act[lanes[j*NZ+k]];
          b.cnt++;
        end
      end
      b.pass = j;
      b.last = (j == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  // Compare process: checks DUT against the model mid-cycle, then advances the model.
  initial begin : model
    beat_t h;
    bit    exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        continue;
      end
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        check("out_data", out_data, h.data);
        check("out_cnt", out_cnt, h.cnt);
        check("out_pass", out_pass, h.pass);
        check("out_last", out_last, h.last);
      end
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      check("in_ready", in_ready, exp_rdy);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (exp_rdy && in_valid) push_group(in_znz, in_act);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a group until accepted; returns just after the accepting edge.
  task automatic send(input logic [GS-1:0] znz);
    bit acc;
    in_valid = 1'b1;
    in_znz   = znz;
    for (int t = 0; t < 50; t++) begin
      #1;
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 0, 1);
  endtask

  task automatic seq_act();
    for (int i = 0; i < GS; i++) in_act[i] = DW'(i + 1);
  endtask

  initial begin : stim
    logic [GS-1:0] z;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_znz = '0;
    seq_act();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // two sparse lanes
    out_ready = 1'b1;
    send(32'h0000_0005);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 128'h0301);
    check("t2_cnt", out_cnt, 2);
    check("t2_pass", out_pass, 0);
    check("t2_last", out_last, 1);
    tick();
    check("t2_done", out_valid, 0);

    // dense group splits into two beats
    send(32'hFFFF_FFFF);
    check("t3_b0_d0", out_data[0], 1);
    check("t3_b0_d15", out_data[15], 16);
    check("t3_b0_cnt", out_cnt, 16);
    check("t3_b0_last", out_last, 0);
    tick();
    check("t3_b1_d0", out_data[0], 17);
    check("t3_b1_d15", out_data[15], 32);
    check("t3_b1_pass", out_pass, 1);
    check("t3_b1_last", out_last, 1);
    tick();

    // stall on beat 0
    out_ready = 1'b0;
    send(32'hFFFF_FFFF);
    for (int r = 0; r < 3; r++) begin
      #1;
      check("t4_hold_d0", out_data[0], 1);
      check("t4_hold_pass", out_pass, 0);
      check("t4_hold_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t4_b1_pass", out_pass, 1);
    check("t4_b1_d0", out_data[0], 17);
    tick();

    // back-to-back stream
    in_valid = 1'b1;
    in_znz   = 32'h00FF_0000;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("t5_valid", out_valid, 1);
      check("t5_cnt", out_cnt, 8);
      check("t5_d0", out_data[0], 17);
      check("t5_d7", out_data[7], 24);
    end
    in_valid = 1'b0;
    tick();
    check("t5_done", out_valid, 0);

    // empty group
    send('0);
    if (SKIP) begin
      check("t6_novalid", out_valid, 0);
      check("t6_rdy", in_ready, 1);
    end else begin
      check("t6_valid", out_valid, 1);
      check("t6_cnt", out_cnt, 0);
      check("t6_last", out_last, 1);
      check("t6_data", out_data, 0);
    end
    tick();

    // reset in the middle of a stalled beat
    out_ready = 1'b0;
    send(32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check("t1_valid", out_valid, 0);
    check("t1_cnt", out_cnt, 0);
    check("t1_rdy", in_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("t1_nobeat", out_valid, 0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0: z = '0;
        1: z = '1;
        2: z = $urandom;
        3: z = $urandom & $urandom & $urandom;
        4: z = 32'h0000_FFFF << $urandom_range(0, 16);
        default: z = 32'h1 << $urandom_range(0, 31);
      endcase
      in_znz    = z;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < GS; i++) in_act[i] = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
